// File: rtl/or1k_pcu_ext.sv
// rtl/or1k_pcu_ext.sv - OR1K SPR-mapped performance counter unit; optional PCU_FREEZE_ON_OVF_EN
module or1k_pcu_ext #(
    parameter int NUM_COUNTERS  = 8,
    parameter int COUNTER_WIDTH = 48,
    parameter int NUM_EVENTS    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spr_access_i,
    input  logic                  spr_we_i,
    input  logic                  spr_re_i,
    input  logic [15:0]           spr_addr_i,
    input  logic [31:0]           spr_dat_i,
    output logic                  spr_bus_ack,
    output logic [31:0]           spr_dat_o,
    input  logic                  spr_sys_mode_i,
    input  logic [NUM_EVENTS-1:0] pcu_events_i,
    output logic                  pcu_irq_o
);

    localparam int CW = COUNTER_WIDTH;
    localparam int IW = $clog2(NUM_EVENTS + 1);
    // Writable PCMR bits: CISM, CIUM, event mask, OVIE (CP is synthesised on read)
    localparam logic [31:0] PCMR_WMASK = 32'h8000_0006 | (((32'd1 << NUM_EVENTS) - 32'd1) << 3);

    logic [CW-1:0]           r_cnt  [NUM_COUNTERS];
    logic [31:0]             r_pcmr [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] r_ovf;
    logic [31:0]             r_shadow;
    logic                    r_irq;

    logic [4:0]              w_off;
    logic [2:0]              w_idx;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_slot_ok;
    logic                    w_freeze;
    logic [NUM_COUNTERS-1:0] w_ovie;
    logic [NUM_COUNTERS-1:0] w_en;
    logic [NUM_COUNTERS-1:0] w_ovf_set;
    logic [NUM_COUNTERS-1:0] w_ovf_clr;
    logic [NUM_COUNTERS-1:0] w_ovf_nxt;
    logic [CW:0]             w_sum     [NUM_COUNTERS];
    logic [CW-1:0]           w_cnt_nxt [NUM_COUNTERS];
    logic [63:0]             w_sel_cnt;
    logic [31:0]             w_sel_pcmr;

    function automatic logic [IW-1:0] popcount(input logic [NUM_EVENTS-1:0] v);
        logic [IW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_EVENTS; i++) c = c + IW'(v[i]);
        return c;
    endfunction

    // Replace the low word, keep upper counter bits
    function automatic logic [CW-1:0] merge_lo(input logic [CW-1:0] c, input logic [31:0] d);
        logic [63:0] t;
        t = 64'(c);
        t[31:0] = d;
        return t[CW-1:0];
    endfunction

    // Replace the upper bits; data bits beyond the counter width fall off
    function automatic logic [CW-1:0] merge_hi(input logic [CW-1:0] c, input logic [31:0] d);
        logic [63:0] t;
        t = 64'(c);
        t[63:32] = d;
        return t[CW-1:0];
    endfunction

    assign w_off       = spr_addr_i[4:0];
    assign w_idx       = w_off[2:0];
    assign w_wr        = spr_access_i & spr_we_i & spr_sys_mode_i;
    assign w_rd        = spr_access_i & spr_re_i;
    assign w_slot_ok   = ({29'd0, w_idx} < 32'(NUM_COUNTERS));
    assign spr_bus_ack = spr_access_i;
    assign pcu_irq_o   = r_irq;
    assign w_ovf_clr   = (w_wr && w_off == 5'd24) ? spr_dat_i[NUM_COUNTERS-1:0] : '0;
    assign w_ovf_nxt   = (r_ovf & ~w_ovf_clr) | w_ovf_set;

`ifdef PCU_FREEZE_ON_OVF_EN
    assign w_freeze = |(r_ovf & w_ovie);
`else
    assign w_freeze = 1'b0;
`endif

    // Per-counter next value: increment by masked popcount, SPR write overrides
    always_comb begin
        for (int n = 0; n < NUM_COUNTERS; n++) begin
            w_ovie[n]     = r_pcmr[n][31];
            w_en[n]       = ((r_pcmr[n][1] & spr_sys_mode_i) | (r_pcmr[n][2] & ~spr_sys_mode_i)) & ~w_freeze;
            w_sum[n]      = {1'b0, r_cnt[n]} + (CW+1)'(popcount(pcu_events_i & r_pcmr[n][3 +: NUM_EVENTS]));
            w_cnt_nxt[n]  = w_en[n] ? w_sum[n][CW-1:0] : r_cnt[n];
            w_ovf_set[n]  = w_en[n] & w_sum[n][CW];
            if (w_wr && w_idx == 3'(n) && w_off[4:3] == 2'b00) begin
                w_cnt_nxt[n] = merge_lo(r_cnt[n], spr_dat_i);
                w_ovf_set[n] = 1'b0;
            end else if (w_wr && w_idx == 3'(n) && w_off[4:3] == 2'b10) begin
                w_cnt_nxt[n] = merge_hi(r_cnt[n], spr_dat_i);
                w_ovf_set[n] = 1'b0;
            end
        end
    end

    // Combinational SPR read mux; PCCRH returns the shadow captured by the last PCCR read
    always_comb begin
        w_sel_cnt  = '0;
        w_sel_pcmr = '0;
        for (int n = 0; n < NUM_COUNTERS; n++) begin
            if (w_idx == 3'(n)) begin
                w_sel_cnt  = 64'(r_cnt[n]);
                w_sel_pcmr = r_pcmr[n] | 32'd1;
            end
        end
        spr_dat_o = '0;
        if (w_rd) begin
            case (w_off[4:3])
                2'b00:   spr_dat_o = w_slot_ok ? w_sel_cnt[31:0] : 32'd0;
                2'b01:   spr_dat_o = (w_slot_ok && spr_sys_mode_i) ? w_sel_pcmr : 32'd0;
                2'b10:   spr_dat_o = w_slot_ok ? r_shadow : 32'd0;
                default: spr_dat_o = (w_idx == 3'd0) ? 32'(r_ovf) : 32'd0;
            endcase
        end
    end

    // State update: counters, mode registers, overflow status, shadow, interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_COUNTERS; n++) begin
                r_cnt[n]  <= '0;
                r_pcmr[n] <= '0;
            end
            r_ovf    <= '0;
            r_shadow <= '0;
            r_irq    <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_COUNTERS; n++) begin
                r_cnt[n] <= w_cnt_nxt[n];
                if (w_wr && w_idx == 3'(n) && w_off[4:3] == 2'b01)
                    r_pcmr[n] <= spr_dat_i & PCMR_WMASK;
            end
            r_ovf <= w_ovf_nxt;
            r_irq <= |(w_ovf_nxt & w_ovie);
            if (w_rd && w_off[4:3] == 2'b00 && w_slot_ok)
                r_shadow <= w_sel_cnt[63:32];
        end
    end

endmodule

// File: tb/tb_or1k_pcu_ext.sv
// tb/tb_or1k_pcu_ext.sv - directed self-checking bench for or1k_pcu_ext
module tb_or1k_pcu_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic        spr_access_i, spr_we_i, spr_re_i, spr_sys_mode_i;
    logic [15:0] spr_addr_i;
    logic [31:0] spr_dat_i;
    logic        spr_bus_ack;
    logic [31:0] spr_dat_o;
    logic [10:0] pcu_events_i;
    logic        pcu_irq_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] rd;

    or1k_pcu_ext #(.NUM_COUNTERS(8), .COUNTER_WIDTH(48), .NUM_EVENTS(11)) dut (
        .clk            (clk),
        .rst            (rst),
        .spr_access_i   (spr_access_i),
        .spr_we_i       (spr_we_i),
        .spr_re_i       (spr_re_i),
        .spr_addr_i     (spr_addr_i),
        .spr_dat_i      (spr_dat_i),
        .spr_bus_ack    (spr_bus_ack),
        .spr_dat_o      (spr_dat_o),
        .spr_sys_mode_i (spr_sys_mode_i),
        .pcu_events_i   (pcu_events_i),
        .pcu_irq_o      (pcu_irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic spr_wr(input logic [4:0] a, input logic [31:0] d, input logic sys);
        @(negedge clk);
        spr_access_i = 1'b1; spr_we_i = 1'b1; spr_re_i = 1'b0;
        spr_addr_i = {11'd0, a}; spr_dat_i = d; spr_sys_mode_i = sys;
        @(posedge clk); #1;
        spr_access_i = 1'b0; spr_we_i = 1'b0; spr_sys_mode_i = 1'b1;
    endtask

    task automatic spr_rd(input logic [4:0] a, input logic sys, output logic [31:0] d);
        @(negedge clk);
        spr_access_i = 1'b1; spr_we_i = 1'b0; spr_re_i = 1'b1;
        spr_addr_i = {11'd0, a}; spr_sys_mode_i = sys;
        #1 d = spr_dat_o;
        @(posedge clk); #1;
        spr_access_i = 1'b0; spr_re_i = 1'b0; spr_sys_mode_i = 1'b1;
    endtask

    task automatic pulse_events(input logic [10:0] ev, input int cycles);
        @(negedge clk);
        pcu_events_i = ev;
        repeat (cycles) @(negedge clk);
        pcu_events_i = '0;
    endtask

    initial begin
        rst = 1'b1; spr_access_i = 1'b0; spr_we_i = 1'b0; spr_re_i = 1'b0;
        spr_addr_i = '0; spr_dat_i = '0; spr_sys_mode_i = 1'b1; pcu_events_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("irq_reset", pcu_irq_o, 0);
        chk("dat_idle", spr_dat_o, 0);
        chk("ack_idle", spr_bus_ack, 0);
        for (int i = 0; i < 8; i++) begin
            spr_rd(5'(8 + i), 1'b1, rd);
            chk($sformatf("pcmr%0d_reset", i), rd, 32'h1);
        end
        spr_rd(5'd0, 1'b1, rd);
        chk("pccr0_reset", rd, 0);
        spr_rd(5'd11, 1'b0, rd);
        chk("pcmr3_user", rd, 0);
        @(negedge clk);
        spr_access_i = 1'b1;
        #1 chk("ack_same_cycle", spr_bus_ack, 1);
        spr_access_i = 1'b0;

        // Basic counting
        spr_wr(5'd8, 32'h0000_000E, 1'b1);
        spr_rd(5'd8, 1'b1, rd);
        chk("pcmr0_rb", rd, 32'h0000_000F);
        pulse_events(11'h001, 5);
        spr_rd(5'd0, 1'b1, rd);
        chk("pccr0_5", rd, 5);
        spr_wr(5'd8, 32'h0000_001E, 1'b1);
        pulse_events(11'h003, 4);
        spr_rd(5'd0, 1'b1, rd);
        chk("pccr0_13", rd, 13);

        // Overflow and interrupt on counter 2
        spr_wr(5'd10, 32'h8000_003E, 1'b1);
        spr_wr(5'd18, 32'h0000_FFFF, 1'b1);
        spr_wr(5'd2, 32'hFFFF_FFFE, 1'b1);
        chk("irq_pre_ovf", pcu_irq_o, 0);
        @(negedge clk);
        pcu_events_i = 11'h007;
        @(negedge clk);
        pcu_events_i = '0;
        chk("irq_after_ovf", pcu_irq_o, 1);
        spr_rd(5'd24, 1'b1, rd);
        chk("pcovr_4", rd, 32'h4);
        spr_rd(5'd2, 1'b1, rd);
        chk("pccr2_wrap", rd, 1);
        spr_rd(5'd18, 1'b1, rd);
        chk("pccrh2_wrap", rd, 0);
        spr_wr(5'd24, 32'h4, 1'b1);
        chk("irq_cleared", pcu_irq_o, 0);
        spr_rd(5'd24, 1'b1, rd);
        chk("pcovr_cleared", rd, 0);

        // Coherent read through the shadow on counter 3
        spr_wr(5'd11, 32'h0000_000E, 1'b1);
        spr_wr(5'd19, 32'h0, 1'b1);
        spr_wr(5'd3, 32'hFFFF_FFFF, 1'b1);
        spr_rd(5'd3, 1'b1, rd);
        chk("pccr3_lo", rd, 32'hFFFF_FFFF);
        pulse_events(11'h001, 1);
        spr_rd(5'd19, 1'b1, rd);
        chk("pccrh3_shadow", rd, 0);
        spr_rd(5'd3, 1'b1, rd);
        chk("pccr3_lo2", rd, 0);
        spr_rd(5'd19, 1'b1, rd);
        chk("pccrh3_new", rd, 1);

        // Write beats a same-cycle increment; user-mode writes ignored
        spr_wr(5'd9, 32'h0000_000E, 1'b1);
        @(negedge clk);
        pcu_events_i = 11'h001;
        spr_wr(5'd1, 32'd100, 1'b1);
        pcu_events_i = '0;
        spr_rd(5'd1, 1'b1, rd);
        chk("pccr1_write_wins", rd, 100);
        spr_wr(5'd1, 32'd555, 1'b0);
        spr_rd(5'd1, 1'b0, rd);
        chk("pccr1_user_wr_ign", rd, 100);
        spr_wr(5'd25, 32'hFFFF_FFFF, 1'b1);
        spr_rd(5'd25, 1'b1, rd);
        chk("off25_zero", rd, 0);

        // Overflow of counter 0 with OVIE; counter 1 freezes only with the freeze option
        spr_wr(5'd8, 32'h8000_000E, 1'b1);
        spr_wr(5'd16, 32'h0000_FFFF, 1'b1);
        spr_wr(5'd0, 32'hFFFF_FFFF, 1'b1);
        pulse_events(11'h001, 3);
        chk("irq_c0_ovf", pcu_irq_o, 1);
        spr_rd(5'd24, 1'b1, rd);
        chk("pcovr_1", rd, 32'h1);
        spr_rd(5'd1, 1'b1, rd);
`ifdef PCU_FREEZE_ON_OVF_EN
        chk("pccr1_frozen", rd, 101);
        spr_rd(5'd0, 1'b1, rd);
        chk("pccr0_frozen", rd, 0);
`else
        chk("pccr1_running", rd, 103);
        spr_rd(5'd0, 1'b1, rd);
        chk("pccr0_running", rd, 2);
`endif
        spr_wr(5'd24, 32'h1, 1'b1);
        chk("irq_c0_clr", pcu_irq_o, 0);
        pulse_events(11'h001, 2);
        spr_rd(5'd1, 1'b1, rd);
`ifdef PCU_FREEZE_ON_OVF_EN
        chk("pccr1_resumed", rd, 103);
`else
        chk("pccr1_resumed", rd, 105);
`endif

        // Reset mid-operation
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("irq_rst2", pcu_irq_o, 0);
        spr_rd(5'd1, 1'b1, rd);
        chk("pccr1_rst2", rd, 0);
        spr_rd(5'd9, 1'b1, rd);
        chk("pcmr1_rst2", rd, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
